timer_multicanal: RTL and testbench

TIMER_MULTICANAL -- requirements
Module: timer_multicanal

---
 rtl/timer_multicanal.sv | 111 +++++++++++
 tb/tb_timer_multicanal.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multicanal.sv
// Multi-channel seconds countdown timer with a shared free-running prescaler.
// Each channel keeps its own sub-second counter so its timing is independent of the prescaler phase.
module timer_multicanal #(
  parameter int CLK_DIV = 100,
  parameter int N_CH    = 2,
  parameter int VAL_W   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         start_timer,
  input  logic [N_CH-1:0]         abort,
  input  logic [N_CH*VAL_W-1:0]   value,
  output logic [N_CH-1:0]         expired,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH*VAL_W-1:0]   counter,
  output logic                    one_hz_enable,
  output logic                    two_hz_enable
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_EXPIRED  = 2'd2
  } ch_state_t;

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Decoded from the prescaler register, so both strobes are 0 while in reset.
  assign one_hz_enable = (presc_q == LAST);
  assign two_hz_enable = (presc_q == LAST) || (presc_q == HALF);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ch_state_t        state_q, state_d;
    logic [PW-1:0]    sub_q, sub_d;
    logic [VAL_W-1:0] cnt_q, cnt_d;
    logic             busy_q, expired_q;
    logic [VAL_W-1:0] val_in;

    assign val_in = value[gi*VAL_W +: VAL_W];

    always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      cnt_d   = cnt_q;
      if (abort[gi]) begin
        state_d = ST_IDLE;
        sub_d   = '0;
        cnt_d   = '0;
      end else if (start_timer[gi]) begin
        sub_d = '0;
        if (val_in != '0) begin
          state_d = ST_COUNTING;
          cnt_d   = val_in;
        end else begin
          state_d = ST_EXPIRED;
          cnt_d   = '0;
        end
      end else if (state_q == ST_COUNTING) begin
        if (sub_q == LAST) begin
          sub_d = '0;
          // Testing <= 1 rather than == 1 keeps the counter from ever wrapping below zero.
          if (cnt_q <= VAL_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_EXPIRED;
          end else begin
            cnt_d = cnt_q - VAL_W'(1);
          end
        end else begin
          sub_d = sub_q + PW'(1);
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        sub_q     <= '0;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        sub_q     <= sub_d;
        cnt_q     <= cnt_d;
        busy_q    <= (state_d == ST_COUNTING);
        expired_q <= (state_d == ST_EXPIRED);
      end
    end

    assign busy[gi]                     = busy_q;
    assign expired[gi]                  = expired_q;
    assign counter[gi*VAL_W +: VAL_W]   = cnt_q;
  end

endmodule

// File: tb/tb_timer_multicanal.sv
// Bench for timer_multicanal: directed scenarios plus random traffic checked against
// an elapsed-time reference model of each channel.
module tb_timer_multicanal;

  localparam int CLK_DIV = 10;
  localparam int N_CH    = 2;
  localparam int VAL_W   = 4;

  logic                  clock;
  logic                  reset;
  logic [N_CH-1:0]       start_timer;
  logic [N_CH-1:0]       abort;
  logic [N_CH*VAL_W-1:0] value;
  logic [N_CH-1:0]       expired;
  logic [N_CH-1:0]       busy;
  logic [N_CH*VAL_W-1:0] counter;
  logic                  one_hz_enable;
  logic                  two_hz_enable;

  int tests = 0;
  int fails = 0;

  timer_multicanal #(.CLK_DIV(CLK_DIV), .N_CH(N_CH), .VAL_W(VAL_W)) dut (
    .clock(clock), .reset(reset), .start_timer(start_timer), .abort(abort),
    .value(value), .expired(expired), .busy(busy), .counter(counter),
    .one_hz_enable(one_hz_enable), .two_hz_enable(two_hz_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: 0 = idle, 1 = loaded with nonzero value, 2 = started with zero.
  int     m_mode [N_CH];
  int     m_val  [N_CH];
  longint m_start[N_CH];
  longint m_cyc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cyc = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_mode[c] = 0; m_val[c] = 0; m_start[c] = 0;
      end
    end else begin
      m_cyc = m_cyc + 1;
      for (int c = 0; c < N_CH; c++) begin
        if (abort[c]) begin
          m_mode[c] = 0;
        end else if (start_timer[c]) begin
          if (value[c*VAL_W +: VAL_W] == 0) begin
            m_mode[c] = 2;
          end else begin
            m_mode[c]  = 1;
            m_val[c]   = int'(value[c*VAL_W +: VAL_W]);
            m_start[c] = m_cyc;
          end
        end
      end
    end
  end

  function automatic int m_counter(int c);
    longint el, r;
    if (m_mode[c] != 1) return 0;
    el = m_cyc - m_start[c];
    r  = m_val[c] - el / CLK_DIV;
    return (r < 0) ? 0 : int'(r);
  endfunction

  function automatic bit m_busy(int c);
    return (m_mode[c] == 1) && ((m_cyc - m_start[c]) < m_val[c] * CLK_DIV);
  endfunction

  function automatic bit m_expired(int c);
    return (m_mode[c] == 2) || ((m_mode[c] == 1) && ((m_cyc - m_start[c]) >= m_val[c] * CLK_DIV));
  endfunction

  function automatic bit m_one();
    return (m_cyc % CLK_DIV) == CLK_DIV - 1;
  endfunction

  function automatic bit m_two();
    return (m_cyc % (CLK_DIV / 2)) == CLK_DIV / 2 - 1;
  endfunction

  function automatic logic [VAL_W-1:0] cnt_of(int c);
    return counter[c*VAL_W +: VAL_W];
  endfunction

  task automatic test_reset();
    reset = 1'b1; start_timer = '0; abort = '0; value = '0;
    repeat (3) @(negedge clock);
    tests++;
    if ({expired, busy, counter, one_hz_enable, two_hz_enable} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got exp=%b busy=%b cnt=%h 1hz=%b 2hz=%b, need all 0",
               expired, busy, counter, one_hz_enable, two_hz_enable);
    end
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (two_hz_enable !== ((k % 5) == 4) || one_hz_enable !== ((k % 10) == 9)) begin
        fails++;
        $display("FAIL prescaler_cycle%0d: got 2hz=%b 1hz=%b, need 2hz=%b 1hz=%b",
                 k, two_hz_enable, one_hz_enable, (k % 5) == 4, (k % 10) == 9);
      end
      tests++;
      if (expired !== '0 || busy !== '0) begin
        fails++;
        $display("FAIL idle_levels_cycle%0d: got exp=%b busy=%b, need 0", k, expired, busy);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_count3();
    start_timer = 2'b01; value = {4'd0, 4'd3};
    @(negedge clock);
    start_timer = '0; value = {4'd9, 4'd9};
    for (int k = 0; k <= 45; k++) begin
      if (k % 10 == 0 && k <= 30) begin
        tests++;
        if (cnt_of(0) !== 4'(3 - k / 10)) begin
          fails++;
          $display("FAIL count3_counter_at+%0d: got %0d, need %0d", k, cnt_of(0), 3 - k / 10);
        end
      end
      tests++;
      if (expired[0] !== (k >= 30) || busy[0] !== (k < 30)) begin
        fails++;
        $display("FAIL count3_levels_at+%0d: got exp=%b busy=%b, need exp=%b busy=%b",
                 k, expired[0], busy[0], k >= 30, k < 30);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_zero_and_five();
    start_timer = 2'b11; value = {4'd0, 4'd5};
    @(negedge clock);
    start_timer = '0;
    for (int k = 0; k <= 55; k++) begin
      tests++;
      if (expired[1] !== 1'b1 || busy[1] !== 1'b0 || cnt_of(1) !== 4'd0) begin
        fails++;
        $display("FAIL zero_ch1_at+%0d: got exp=%b busy=%b cnt=%0d, need 1 0 0",
                 k, expired[1], busy[1], cnt_of(1));
      end
      tests++;
      if (expired[0] !== (k >= 50) || cnt_of(0) !== 4'(m_counter(0))) begin
        fails++;
        $display("FAIL five_ch0_at+%0d: got exp=%b cnt=%0d, need exp=%b cnt=%0d",
                 k, expired[0], cnt_of(0), k >= 50, m_counter(0));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_restart();
    abort = 2'b11;
    @(negedge clock);
    abort = '0; start_timer = 2'b01; value = {4'd0, 4'd4};
    @(negedge clock);
    start_timer = '0;
    repeat (15) @(negedge clock);
    start_timer = 2'b01; value = {4'd0, 4'd2};
    @(negedge clock);
    start_timer = '0; value = {4'd0, 4'd7};
    for (int k = 0; k <= 24; k++) begin
      tests++;
      if (cnt_of(0) !== 4'(m_counter(0)) || expired[0] !== (k >= 20) || busy[0] !== (k < 20)) begin
        fails++;
        $display("FAIL restart_at+%0d: got cnt=%0d exp=%b busy=%b, need cnt=%0d exp=%b busy=%b",
                 k, cnt_of(0), expired[0], busy[0], m_counter(0), k >= 20, k < 20);
      end
      if (k == 0) begin
        tests++;
        if (cnt_of(0) !== 4'd2) begin
          fails++;
          $display("FAIL restart_load: got %0d, need 2", cnt_of(0));
        end
      end
      @(negedge clock);
    end
    start_timer = 2'b01; abort = 2'b01; value = {4'd0, 4'd5};
    @(negedge clock);
    start_timer = '0; abort = '0;
    tests++;
    if (cnt_of(0) !== 4'd0 || expired[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_wins: got cnt=%0d exp=%b busy=%b, need 0 0 0",
               cnt_of(0), expired[0], busy[0]);
    end
  endtask

  task automatic test_reset_midcount();
    start_timer = 2'b01; value = {4'd0, 4'd6};
    @(negedge clock);
    start_timer = '0;
    repeat (25) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({expired, busy, counter, one_hz_enable, two_hz_enable} !== '0) begin
      fails++;
      $display("FAIL async_reset: got exp=%b busy=%b cnt=%h 1hz=%b 2hz=%b, need all 0",
               expired, busy, counter, one_hz_enable, two_hz_enable);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tests++;
      if (busy !== '0 || expired !== '0 || counter !== '0) begin
        fails++;
        $display("FAIL post_reset_idle_%0d: got busy=%b exp=%b cnt=%h, need 0", k, busy, expired, counter);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_max();
    start_timer = 2'b01; value = {4'd0, 4'd15};
    @(negedge clock);
    start_timer = '0;
    for (int k = 0; k <= 160; k++) begin
      tests++;
      if (cnt_of(0) !== 4'(m_counter(0)) || expired[0] !== (k >= 150)) begin
        fails++;
        $display("FAIL max_at+%0d: got cnt=%0d exp=%b, need cnt=%0d exp=%b",
                 k, cnt_of(0), expired[0], m_counter(0), k >= 150);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        tests++;
        if (cnt_of(c) !== 4'(m_counter(c)) || busy[c] !== m_busy(c) || expired[c] !== m_expired(c)) begin
          fails++;
          $display("FAIL random_%0d_ch%0d: got cnt=%0d busy=%b exp=%b, need cnt=%0d busy=%b exp=%b",
                   k, c, cnt_of(c), busy[c], expired[c], m_counter(c), m_busy(c), m_expired(c));
        end
      end
      tests++;
      if (one_hz_enable !== m_one() || two_hz_enable !== m_two()) begin
        fails++;
        $display("FAIL random_hz_%0d: got 1hz=%b 2hz=%b, need 1hz=%b 2hz=%b",
                 k, one_hz_enable, two_hz_enable, m_one(), m_two());
      end
      for (int c = 0; c < N_CH; c++) begin
        start_timer[c] = ($urandom_range(0, 24) == 0);
        abort[c]       = ($urandom_range(0, 59) == 0);
        value[c*VAL_W +: VAL_W] = VAL_W'($urandom_range(0, 4));
      end
      @(negedge clock);
    end
    start_timer = '0; abort = '0;
  endtask

  initial begin
    test_reset();
    test_count3();
    test_zero_and_five();
    test_restart();
    test_reset_midcount();
    test_max();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
